ifu_fetch: RTL and testbench

//  Instruction fetch stage: owns the architectural PC, fetches one 32-bit instruction
//  at a time from instruction memory over a valid/ready request + valid response

---
 rtl/ifu_fetch_pkg.sv | 21 ++
 rtl/ifu_fetch.sv | 98 +++++++++
 tb/tb_ifu_fetch.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// reset PC default and the canonical NOP encoding.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam int          DATA_WIDTH_DEFAULT = 32;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h8000_0000;
  localparam logic [31:0] INST_NOP           = 32'h0000_0013;

  // A redirect target is misaligned when either low address bit is set.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one blocking fetch at a time,
// holds the returned instruction until decode/execute accepts it, then picks
// the next PC from the execute stage's jump/upc.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] pc,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] upc,
  output logic                  misalign
);

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_inst;
  logic                  r_misalign;
  logic                  w_accept;
  logic                  w_capture;
  logic [DATA_WIDTH-1:0] w_pc_next;

  // Handshake qualifiers: a response only counts while waiting for one, and
  // jump/upc only matter in the cycle the held instruction is accepted.
  assign w_accept  = (r_state == S_HOLD) && inst_ready;
  assign w_capture = (r_state == S_WAIT) && imem_rsp_valid;

  // Next PC: redirect target with low bits forced to zero, else sequential
  // (pc+4 wraps naturally at the top of the address space).
  assign w_pc_next = jump ? {upc[DATA_WIDTH-1:2], 2'b00}
                          : r_pc + DATA_WIDTH'(4);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode and Moore outputs.
  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would infer a latch.
  always_comb begin
    w_state_next   = r_state;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    unique case (r_state)
      S_IDLE: w_state_next = S_REQ;
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) w_state_next = S_HOLD;
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) w_state_next = S_REQ;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: PC advance on accept, instruction capture on response, and the
  // sticky misaligned-redirect flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_inst     <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_capture) r_inst <= imem_rsp_data;
      if (w_accept) begin
        r_pc <= w_pc_next;
        if (jump && is_misaligned(upc[1:0])) r_misalign <= 1'b1;
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign inst      = r_inst;
  assign misalign  = r_misalign;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a memory responder with one-cycle
// latency, an address/instruction scoreboard, and directed scenario tasks.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        jump;
  logic [31:0] upc;
  logic        misalign;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          n_accepts = 0;
  logic        mem_auto;
  logic        pending;
  logic [31:0] pending_addr;
  logic [31:0] exp_addr;

  ifu_fetch #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .jump(jump), .upc(upc), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Monitor, scoreboard and memory model, all acting on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pending  = 1'b0;
      exp_addr = RST_PC;
      sb.delete();
      if (mem_auto) imem_rsp_valid = 1'b0;
    end else begin
      if (inst_valid && inst_ready) begin
        n_accepts++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL accept_without_fetch pc=%h", pc);
        end else begin
          e = sb.pop_front();
          if (pc !== e.pc || inst !== e.inst) begin
            errors++;
            $display("FAIL accept_data got pc=%h inst=%h want pc=%h inst=%h",
                     pc, inst, e.pc, e.inst);
          end
          exp_addr = jump ? {upc[31:2], 2'b00} : e.pc + 32'd4;
        end
      end
      if (mem_auto) begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = INST_NOP;
        if (pending) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = inst_of(pending_addr);
          pending        = 1'b0;
        end
        if (imem_req_valid && imem_req_ready) begin
          checks++;
          if (imem_addr !== exp_addr) begin
            errors++;
            $display("FAIL fetch_addr got %h want %h", imem_addr, exp_addr);
          end
          sb.push_back('{pc: exp_addr, inst: inst_of(exp_addr)});
          pending      = 1'b1;
          pending_addr = imem_addr;
        end
      end
    end
  end

  // Wait for the next instruction accept; returns falling edges waited and
  // leaves control just after the rising edge that completed the handshake.
  task automatic wait_accept(output int cycles);
    int start;
    start  = n_accepts;
    cycles = 0;
    while (n_accepts == start && cycles < 50) begin
      @(negedge clk); #1;
      cycles++;
    end
    if (n_accepts == start) begin
      checks++; errors++;
      $display("FAIL accept_timeout waited %0d cycles", cycles);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_auto = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    jump = 1'b0; upc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = INST_NOP;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_dead_cycle", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_addr, RST_PC);
  endtask

  task automatic test_sequential();
    int c;
    for (int i = 0; i < 3; i++) begin
      wait_accept(c);
      chk("seq_latency", 32'(c), 32'd3);
    end
    chk("seq_next_addr", imem_addr, 32'h8000_000C);
  endtask

  task automatic test_req_stall();
    int c;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
      chk("stall_req_addr", imem_addr, 32'h8000_000C);
      chk("stall_no_inst", 32'(inst_valid), 32'd0);
    end
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    wait_accept(c);
    chk("stall_resume_latency", 32'(c), 32'd3);
  endtask

  task automatic test_inst_stall_jump();
    int c;
    int t;
    inst_ready = 1'b0;
    jump = 1'b1; upc = 32'h1234_5677;
    t = 0;
    while (!inst_valid && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk("hold_reached", 32'(inst_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("hold_pc", pc, 32'h8000_0010);
      chk("hold_inst", inst, inst_of(32'h8000_0010));
      chk("hold_no_req", 32'(imem_req_valid), 32'd0);
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    inst_ready = 1'b1; jump = 1'b1; upc = 32'h8000_0100;
    wait_accept(c);
    jump = 1'b0;
    chk("jal_target", imem_addr, 32'h8000_0100);
    chk("jal_no_misalign", 32'(misalign), 32'd0);
  endtask

  task automatic test_misalign();
    int c;
    jump = 1'b1; upc = 32'h8000_0102;
    wait_accept(c);
    jump = 1'b0;
    chk("mis_target", imem_addr, 32'h8000_0100);
    chk("mis_flag", 32'(misalign), 32'd1);
    wait_accept(c);
    chk("mis_sticky", 32'(misalign), 32'd1);
    chk("mis_seq_addr", imem_addr, 32'h8000_0104);
  endtask

  task automatic test_wrap();
    int c;
    jump = 1'b1; upc = 32'hFFFF_FFFC;
    wait_accept(c);
    jump = 1'b0;
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    wait_accept(c);
    chk("wrap_zero", imem_addr, 32'h0000_0000);
  endtask

  task automatic test_reset_mid();
    int c;
    mem_auto = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    repeat (2) begin @(posedge clk); #1; end
    chk("spurious_req_valid", 32'(imem_req_valid), 32'd1);
    chk("spurious_no_inst", 32'(inst_valid), 32'd0);
    chk("spurious_no_capture", inst, inst_of(32'hFFFF_FFFC));
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_in_wait", 32'(imem_req_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_pc", pc, RST_PC);
    chk("mid_rst_inst", inst, 32'd0);
    chk("mid_rst_misalign", 32'(misalign), 32'd0);
    repeat (2) @(negedge clk);
    mem_auto = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_addr", imem_addr, RST_PC);
    wait_accept(c);
    chk("restart_latency", 32'(c), 32'd3);
    chk("restart_next_addr", imem_addr, 32'h8000_0004);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_req_stall();
    test_inst_stall_jump();
    test_misalign();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
